object_spawn_sequencer: RTL and testbench

//  Issuing side of the object load interface. Walks a spawn table, waits each entry's

---
 rtl/object_pkg.sv | 54 +++++
 rtl/object_spawn_sequencer_if.sv | 35 +++
 rtl/object_slot_picker.sv | 29 ++
 rtl/object_spawn_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_object_spawn_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/object_pkg.sv
//------------------------------------------------------------------------------
// object_pkg: spawn-table entry layout, direction and trigger codes. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package object_pkg;

  // First field is the MSB of the table word.
  typedef struct packed {
    logic [7:0] delay_cs;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] w;
    logic [9:0] h;
    logic [2:0] dir;
    logic [4:0] speed;
    logic [7:0] dtime;
    logic [1:0] trig;
    logic       last;
  } spawn_entry_t;

  localparam int ENTRY_W = $bits(spawn_entry_t);

  localparam int LAST_LSB  = 0;
  localparam int TRIG_LSB  = 1;
  localparam int DTIME_LSB = 3;
  localparam int SPEED_LSB = 11;
  localparam int DIR_LSB   = 16;
  localparam int H_LSB     = 19;
  localparam int W_LSB     = 29;
  localparam int Y_LSB     = 39;
  localparam int X_LSB     = 49;
  localparam int DELAY_LSB = 59;

  typedef enum logic [2:0] {
    DIR_U  = 3'd0,
    DIR_UR = 3'd1,
    DIR_R  = 3'd2,
    DIR_DR = 3'd3,
    DIR_D  = 3'd4,
    DIR_DL = 3'd5,
    DIR_L  = 3'd6,
    DIR_UL = 3'd7
  } direction_e;

  typedef enum logic [1:0] {
    TRIG_NONE    = 2'd0,
    TRIG_SCREEN  = 2'd1,
    TRIG_DISPBOX = 2'd2
  } trigger_e;

endpackage

`default_nettype wire

// File: rtl/object_spawn_sequencer_if.sv
//------------------------------------------------------------------------------
// object_spawn_sequencer_if: shared object load bus plus per-slot sync/free. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface object_spawn_sequencer_if #(
  parameter int NUM_SLOTS = 8
);
  logic [2:0]           movement_direction;
  logic [9:0]           object_pos_x;
  logic [9:0]           object_pos_y;
  logic [4:0]           object_speed;
  logic [7:0]           object_destroy_time;
  logic [1:0]           object_destroy_trigger;
  logic [9:0]           object_w;
  logic [9:0]           object_h;
  logic [NUM_SLOTS-1:0] sync_object_position;
  logic [NUM_SLOTS-1:0] object_free;

  modport master (
    output movement_direction, object_pos_x, object_pos_y, object_speed,
           object_destroy_time, object_destroy_trigger, object_w, object_h,
           sync_object_position,
    input  object_free
  );

  modport slave (
    input  movement_direction, object_pos_x, object_pos_y, object_speed,
           object_destroy_time, object_destroy_trigger, object_w, object_h,
           sync_object_position,
    output object_free
  );
endinterface

`default_nettype wire

// File: rtl/object_slot_picker.sv
//------------------------------------------------------------------------------
// object_slot_picker: lowest-index free-slot priority encoder. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module object_slot_picker #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic [NUM_SLOTS-1:0] free,
  output logic                 any_free,
  output logic [SLOT_W-1:0]    slot
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    any_free = 1'b0;
    slot     = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free[i]) begin
        any_free = 1'b1;
        slot     = SLOT_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/object_spawn_sequencer.sv
//------------------------------------------------------------------------------
// object_spawn_sequencer: walks a spawn table and loads free position controllers. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module object_spawn_sequencer
  import object_pkg::spawn_entry_t;
#(
  parameter int NUM_SLOTS    = 8,
  parameter int ADDR_W       = 8,
  parameter int ENTRY_W      = 67,
  parameter int LOAD_HOLD    = 2,
  parameter int SLOT_WAIT_CS = 50
) (
  input  logic                    clk_centi_second,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       pattern_base,
  input  logic                    pause,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [ENTRY_W-1:0]      rom_data,
  output logic                    busy,
  output logic                    pattern_done,
  output logic                    spawn_dropped,
  output logic [7:0]              drop_count,
  object_spawn_sequencer_if.master load_bus
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_PICK    = 3'd3,
    S_LOAD    = 3'd4,
    S_RELEASE = 3'd5,
    S_NEXT    = 3'd6
  } state_t;

  state_t               state;
  logic                 fetch_phase;
  spawn_entry_t         entry;
  spawn_entry_t         rom_entry;
  logic [15:0]          wait_cnt;
  logic [7:0]           hold_cnt;
  logic [1:0]           rel_cnt;
  logic [SLOT_W-1:0]    slot;
  logic [NUM_SLOTS-1:0] free_meta;
  logic [NUM_SLOTS-1:0] free_sync;
  logic                 any_free;
  logic [SLOT_W-1:0]    pick_slot;

  assign rom_entry = rom_data;

  always_ff @(posedge clk_centi_second) begin
    if (reset) begin
      free_meta <= '0;
      free_sync <= '0;
    end else begin
      free_meta <= load_bus.object_free;
      free_sync <= free_meta;
    end
  end

  object_slot_picker #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_picker (
    .free     (free_sync),
    .any_free (any_free),
    .slot     (pick_slot)
  );

  // entry.delay_cs doubles as the WAIT down-counter.
  always_ff @(posedge clk_centi_second) begin
    if (reset) begin
      state                           <= S_IDLE;
      fetch_phase                     <= 1'b0;
      entry                           <= '0;
      wait_cnt                        <= '0;
      hold_cnt                        <= '0;
      rel_cnt                         <= '0;
      slot                            <= '0;
      rom_addr                        <= '0;
      busy                            <= 1'b0;
      pattern_done                    <= 1'b0;
      spawn_dropped                   <= 1'b0;
      drop_count                      <= '0;
      load_bus.sync_object_position   <= '1;
      load_bus.movement_direction     <= '0;
      load_bus.object_pos_x           <= '0;
      load_bus.object_pos_y           <= '0;
      load_bus.object_speed           <= '0;
      load_bus.object_destroy_time    <= '0;
      load_bus.object_destroy_trigger <= '0;
      load_bus.object_w               <= '0;
      load_bus.object_h               <= '0;
    end else begin
      spawn_dropped <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rom_addr     <= pattern_base;
            pattern_done <= 1'b0;
            busy         <= 1'b1;
            fetch_phase  <= 1'b0;
            state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!fetch_phase) begin
            fetch_phase <= 1'b1;
          end else begin
            fetch_phase <= 1'b0;
            entry       <= rom_entry;
            wait_cnt    <= '0;
            state       <= (rom_entry.delay_cs == 8'd0) ? S_PICK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!pause) begin
            if (entry.delay_cs == 8'd1) state <= S_PICK;
            entry.delay_cs <= entry.delay_cs - 8'd1;
          end
        end
        S_PICK: begin
          if (any_free) begin
            slot                            <= pick_slot;
            load_bus.sync_object_position   <= ~(NUM_SLOTS'(1) << pick_slot);
            load_bus.movement_direction     <= entry.dir;
            load_bus.object_pos_x           <= entry.x;
            load_bus.object_pos_y           <= entry.y;
            load_bus.object_speed           <= entry.speed;
            load_bus.object_destroy_time    <= entry.dtime;
            load_bus.object_destroy_trigger <= entry.trig;
            load_bus.object_w               <= entry.w;
            load_bus.object_h               <= entry.h;
            hold_cnt                        <= 8'(LOAD_HOLD - 1);
            state                           <= S_LOAD;
          end else if (!pause) begin
            if (wait_cnt == 16'(SLOT_WAIT_CS - 1)) begin
              spawn_dropped <= 1'b1;
              if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
              state <= S_NEXT;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end
        end
        S_LOAD: begin
          if (hold_cnt == 8'd0) begin
            load_bus.sync_object_position <= '1;
            rel_cnt                       <= '0;
            state                         <= S_RELEASE;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        S_RELEASE: begin
          // The slot's free flag is stale until the controller sees the load.
          if (!free_sync[slot] || rel_cnt == 2'd3) state <= S_NEXT;
          else rel_cnt <= rel_cnt + 2'd1;
        end
        S_NEXT: begin
          if (entry.last) begin
            busy         <= 1'b0;
            pattern_done <= 1'b1;
            state        <= S_IDLE;
          end else begin
            rom_addr    <= rom_addr + ADDR_W'(1);
            fetch_phase <= 1'b0;
            state       <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_object_spawn_sequencer.sv
//------------------------------------------------------------------------------
// tb_object_spawn_sequencer: directed self-checking bench for object_spawn_sequencer. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_object_spawn_sequencer;

  logic        clk_centi_second = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pattern_base;
  logic        pause;
  logic [7:0]  rom_addr;
  logic [66:0] rom_data;
  logic        busy;
  logic        pattern_done;
  logic        spawn_dropped;
  logic [7:0]  drop_count;
  logic [66:0] rom [0:255];

  int errors = 0;
  int checks = 0;

  object_spawn_sequencer_if #(.NUM_SLOTS(8)) bus_if ();

  object_spawn_sequencer dut (
    .clk_centi_second (clk_centi_second),
    .reset            (reset),
    .start            (start),
    .pattern_base     (pattern_base),
    .pause            (pause),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .busy             (busy),
    .pattern_done     (pattern_done),
    .spawn_dropped    (spawn_dropped),
    .drop_count       (drop_count),
    .load_bus         (bus_if.master)
  );

  always #5 clk_centi_second = ~clk_centi_second;

  always @(posedge clk_centi_second) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [66:0] ent(input int d, x, y, w, h, dir, spd, dt, tr, last);
    return {8'(d), 10'(x), 10'(y), 10'(w), 10'(h), 3'(dir), 5'(spd), 8'(dt), 2'(tr), 1'(last)};
  endfunction

  task automatic tick();
    @(posedge clk_centi_second);
    #1;
  endtask

  task automatic do_start(input logic [7:0] base);
    start        = 1'b1;
    pattern_base = base;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_load(output int n);
    n = 0;
    while (bus_if.sync_object_position == 8'hFF && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic measure_hold(output int n);
    n = 0;
    while (bus_if.sync_object_position != 8'hFF && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!pattern_done && n < 300) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int loads;
    logic [7:0] prev;

    reset = 1'b1; start = 1'b0; pattern_base = '0; pause = 1'b0;
    bus_if.object_free = 8'hFF;
    for (int i = 0; i < 256; i++) rom[i] = ent(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) tick();
    reset = 1'b0;

    check("rst_sync",  bus_if.sync_object_position, 8'hFF);
    check("rst_busy",  busy, 0);
    check("rst_done",  pattern_done, 0);
    check("rst_drop",  spawn_dropped, 0);
    check("rst_dcnt",  drop_count, 0);
    check("rst_addr",  rom_addr, 0);
    check("rst_bus_x", bus_if.object_pos_x, 0);

    // 1: single entry, delay 3, all slots free
    rom[0] = ent(3, 100, 50, 20, 30, 2, 4, 99, 1, 1);
    do_start(8'd0);
    check("t1_busy", busy, 1);
    wait_load(n);
    check("t1_latency", n, 6);
    check("t1_sync", bus_if.sync_object_position, 8'hFE);
    check("t1_x",     bus_if.object_pos_x, 100);
    check("t1_y",     bus_if.object_pos_y, 50);
    check("t1_w",     bus_if.object_w, 20);
    check("t1_h",     bus_if.object_h, 30);
    check("t1_dir",   bus_if.movement_direction, 2);
    check("t1_speed", bus_if.object_speed, 4);
    check("t1_dtime", bus_if.object_destroy_time, 99);
    check("t1_trig",  bus_if.object_destroy_trigger, 1);
    measure_hold(n);
    check("t1_hold", n, 2);
    check("t1_bus_hold", bus_if.object_pos_x, 100);
    wait_done(n);
    check("t1_release_timeout", n, 5);
    check("t1_done", pattern_done, 1);
    check("t1_busy_end", busy, 0);

    // 2: lowest free is slot 2; controller clears its free flag early
    bus_if.object_free = 8'hFC;
    repeat (3) tick();
    rom[1] = ent(1, 7, 8, 9, 10, 5, 3, 11, 2, 1);
    do_start(8'd1);
    check("t2_done_clr", pattern_done, 0);
    wait_load(n);
    check("t2_latency", n, 4);
    check("t2_sync", bus_if.sync_object_position, 8'hFB);
    bus_if.object_free = 8'hF8;
    measure_hold(n);
    check("t2_hold", n, 2);
    wait_done(n);
    check("t2_release_early", n, 2);

    // 3: no slot free -> drop, then next entry loads
    bus_if.object_free = 8'h00;
    repeat (3) tick();
    rom[2] = ent(0, 5, 5, 5, 5, 0, 0, 0, 0, 0);
    rom[3] = ent(0, 1, 2, 3, 4, 0, 1, 1, 0, 1);
    do_start(8'd2);
    n = 0;
    while (!spawn_dropped && n < 200) begin
      tick();
      n++;
    end
    check("t3_drop_latency", n, 52);
    check("t3_drop_count", drop_count, 1);
    check("t3_no_load", bus_if.sync_object_position, 8'hFF);
    bus_if.object_free = 8'hFF;
    tick();
    check("t3_drop_pulse", spawn_dropped, 0);
    wait_load(n);
    check("t3_next_latency", n, 3);
    check("t3_next_x", bus_if.object_pos_x, 1);
    wait_done(n);
    check("t3_addr", rom_addr, 3);

    // 4: pause inside WAIT stretches the delay; pause inside LOAD does not
    rom[4] = ent(5, 200, 1, 1, 1, 7, 1, 1, 0, 1);
    do_start(8'd4);
    repeat (3) tick();
    pause = 1'b1;
    repeat (10) tick();
    pause = 1'b0;
    wait_load(n);
    check("t4_paused_latency", 13 + n, 18);
    pause = 1'b1;
    measure_hold(n);
    check("t4_hold_paused", n, 2);
    pause = 1'b0;
    wait_done(n);

    // 5: address wrap 255 -> 0
    rom[255] = ent(1, 11, 1, 1, 1, 1, 1, 1, 0, 0);
    rom[0]   = ent(1, 22, 1, 1, 1, 1, 1, 1, 0, 1);
    do_start(8'd255);
    loads = 0;
    prev  = bus_if.sync_object_position;
    n = 0;
    while (!pattern_done && n < 300) begin
      tick();
      n++;
      if (bus_if.sync_object_position != 8'hFF && prev == 8'hFF) loads++;
      prev = bus_if.sync_object_position;
    end
    check("t5_loads", loads, 2);
    check("t5_wrap_addr", rom_addr, 0);
    check("t5_last_x", bus_if.object_pos_x, 22);

    // 6: start while busy is ignored; reset mid-load releases at once
    rom[10] = ent(4, 333, 1, 1, 1, 1, 1, 1, 0, 1);
    do_start(8'd10);
    repeat (2) tick();
    start = 1'b1;
    pattern_base = 8'd20;
    tick();
    start = 1'b0;
    check("t6_start_ignored", rom_addr, 10);
    wait_load(n);
    check("t6_latency", n, 4);
    reset = 1'b1;
    tick();
    check("t6_rst_sync", bus_if.sync_object_position, 8'hFF);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_bus",  bus_if.object_pos_x, 0);
    check("t6_rst_dcnt", drop_count, 0);
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
